// File: rtl/triangle_area_recip_unit.sv
// Triangle setup: signed doubled area from three Q(FRAC) vertices, saturated area and
// reciprocal (iterative restoring divider), degenerate/backface flags and face culling.
// One triangle in flight, valid/ready on both sides, opaque tag carried through.
module triangle_area_recip_unit #(
    parameter int unsigned W     = 16,
    parameter int unsigned FRAC  = 4,
    parameter int unsigned TAG_W = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic signed [W-1:0]  v0x,
    input  logic signed [W-1:0]  v0y,
    input  logic signed [W-1:0]  v1x,
    input  logic signed [W-1:0]  v1y,
    input  logic signed [W-1:0]  v2x,
    input  logic signed [W-1:0]  v2y,
    input  logic [1:0]           cull_mode,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic signed [W-1:0]  area_out,
    output logic signed [W-1:0]  recip_out,
    output logic                 degenerate,
    output logic                 backface,
    output logic                 culled,
    output logic [TAG_W-1:0]     out_tag
);

    localparam int unsigned DW = W + 1;         // edge deltas
    localparam int unsigned PW = 2 * W + 2;     // cross products
    localparam int unsigned EW = 2 * W + 3;     // doubled area E
    localparam int unsigned N  = 2 * FRAC + 1;  // quotient bits of 2^(2*FRAC)
    localparam int unsigned CW = $clog2(N + 1);

    typedef enum logic [2:0] {StIdle, StDelta, StMul, StArea, StDiv, StDone} state_e;

    state_e r_state, w_state_nx;

    logic signed [DW-1:0]   r_dx1, r_dy1, r_dx2, r_dy2;
    logic signed [PW-1:0]   r_p1, r_p2;
    logic signed [EW-1:0]   r_area;
    logic [1:0]             r_cull;
    logic [EW-1:0]          r_den;
    logic [EW-1:0]          r_rem;
    logic [N-1:0]           r_quot;
    logic [CW-1:0]          r_cnt;
    logic signed [W-1:0]    r_area_out, r_recip_out;
    logic                   r_degenerate, r_backface, r_culled;
    logic [TAG_W-1:0]       r_out_tag;

    logic signed [DW-1:0]   w_dx1, w_dy1, w_dx2, w_dy2;
    logic signed [PW-1:0]   w_p1, w_p2;
    logic signed [EW-1:0]   w_e, w_area;
    logic                   w_degenerate, w_culled;
    logic [EW-1:0]          w_area_mag;
    logic                   w_first;
    logic [EW:0]            w_rem_sh;
    logic                   w_ge;
    logic [EW-1:0]          w_rem_nx;
    logic [N-1:0]           w_quot_nx;
    logic signed [EW-1:0]   w_quot_ext, w_recip;

    // Symmetric clamp to [-(2^(W-1)-1), 2^(W-1)-1]
    function automatic logic signed [W-1:0] sat_w(input logic signed [EW-1:0] x);
        logic signed [EW-1:0] lim;
        lim         = '0;
        lim[W-2:0]  = '1;
        if (x > lim) begin
            sat_w = W'(lim);
        end else if (x < -lim) begin
            sat_w = W'(-lim);
        end else begin
            sat_w = W'(x);
        end
    endfunction

    // Arithmetic for every pipeline step, evaluated on the registered operands
    always_comb begin
        w_dx1 = DW'(v1x) - DW'(v0x);
        w_dy1 = DW'(v1y) - DW'(v0y);
        w_dx2 = DW'(v2x) - DW'(v0x);
        w_dy2 = DW'(v2y) - DW'(v0y);

        w_p1 = PW'(r_dx1) * PW'(r_dy2);
        w_p2 = PW'(r_dy1) * PW'(r_dx2);

        w_e          = EW'(r_p1) - EW'(r_p2);
        w_area       = w_e >>> FRAC;
        w_degenerate = (w_area == '0);
        // E==0 falls in neither branch, so it is never culled
        w_culled     = ((r_cull == 2'd1) && w_e[EW-1]) ||
                       ((r_cull == 2'd2) && !w_e[EW-1] && (w_e != '0));

        w_area_mag = r_area[EW-1] ? EW'(-r_area) : EW'(r_area);

        // Dividend is 2^(2*FRAC): only its top bit (first iteration) is one
        w_first    = (r_cnt == CW'(N - 1));
        w_rem_sh   = {r_rem, w_first};
        w_ge       = (w_rem_sh >= {1'b0, r_den});
        w_rem_nx   = w_ge ? EW'(w_rem_sh - {1'b0, r_den}) : EW'(w_rem_sh);
        w_quot_nx  = N'({r_quot, w_ge});
        w_quot_ext = $signed(EW'(w_quot_nx));
        w_recip    = r_backface ? -w_quot_ext : w_quot_ext;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_nx;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            StIdle:  if (in_valid) w_state_nx = StDelta;
            StDelta: w_state_nx = StMul;
            StMul:   w_state_nx = StArea;
            StArea:  w_state_nx = (r_degenerate || r_culled) ? StDone : StDiv;
            StDiv:   if (r_cnt == '0) w_state_nx = StDone;
            StDone:  if (out_ready) w_state_nx = StIdle;
            default: w_state_nx = StIdle;
        endcase
    end

    // Handshake outputs decoded from state
    always_comb begin
        in_ready  = (r_state == StIdle);
        out_valid = (r_state == StDone);
    end

    // Datapath and result registers, advanced one step per state
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dx1        <= '0;
            r_dy1        <= '0;
            r_dx2        <= '0;
            r_dy2        <= '0;
            r_p1         <= '0;
            r_p2         <= '0;
            r_area       <= '0;
            r_cull       <= '0;
            r_den        <= '0;
            r_rem        <= '0;
            r_quot       <= '0;
            r_cnt        <= '0;
            r_area_out   <= '0;
            r_recip_out  <= '0;
            r_degenerate <= 1'b0;
            r_backface   <= 1'b0;
            r_culled     <= 1'b0;
            r_out_tag    <= '0;
        end else begin
            case (r_state)
                StIdle: begin
                    if (in_valid) begin
                        r_dx1     <= w_dx1;
                        r_dy1     <= w_dy1;
                        r_dx2     <= w_dx2;
                        r_dy2     <= w_dy2;
                        r_cull    <= cull_mode;
                        r_out_tag <= in_tag;
                    end
                end
                StDelta: begin
                    r_p1 <= w_p1;
                    r_p2 <= w_p2;
                end
                StMul: begin
                    r_area       <= w_area;
                    r_area_out   <= sat_w(w_area);
                    r_degenerate <= w_degenerate;
                    r_backface   <= w_e[EW-1];
                    r_culled     <= w_culled;
                end
                StArea: begin
                    r_den  <= w_area_mag;
                    r_rem  <= '0;
                    r_quot <= '0;
                    r_cnt  <= CW'(N - 1);
                    if (r_degenerate || r_culled) begin
                        r_recip_out <= '0;
                    end
                end
                StDiv: begin
                    r_rem  <= w_rem_nx;
                    r_quot <= w_quot_nx;
                    r_cnt  <= r_cnt - CW'(1);
                    if (r_cnt == '0) begin
                        r_recip_out <= sat_w(w_recip);
                    end
                end
                default: ;
            endcase
        end
    end

    assign area_out   = r_area_out;
    assign recip_out  = r_recip_out;
    assign degenerate = r_degenerate;
    assign backface   = r_backface;
    assign culled     = r_culled;
    assign out_tag    = r_out_tag;

endmodule

// File: tb/tb_triangle_area_recip_unit.sv
// Bench for triangle_area_recip_unit: directed cases plus random triangles against a
// plain-arithmetic reference model. Two instances (FRAC=4 and FRAC=8) share inputs.
module tb_triangle_area_recip_unit;

    localparam int W     = 16;
    localparam int TAG_W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst_n;
    logic                sel;   // 0 selects the FRAC=4 instance, 1 the FRAC=8 one
    logic                iv, ordy;
    logic signed [W-1:0] v0x, v0y, v1x, v1y, v2x, v2y;
    logic [1:0]          cm;
    logic [TAG_W-1:0]    tg;

    logic                iv4, ordy4, ir4, ov4, deg4, bf4, cul4;
    logic signed [W-1:0] area4, recip4;
    logic [TAG_W-1:0]    tag4;
    logic                iv8, ordy8, ir8, ov8, deg8, bf8, cul8;
    logic signed [W-1:0] area8, recip8;
    logic [TAG_W-1:0]    tag8;

    assign iv4   = iv & ~sel;
    assign ordy4 = ordy & ~sel;
    assign iv8   = iv & sel;
    assign ordy8 = ordy & sel;

    logic                m_ir, m_ov, m_deg, m_bf, m_cul;
    logic signed [W-1:0] m_area, m_recip;
    logic [TAG_W-1:0]    m_tag;

    assign m_ir    = sel ? ir8 : ir4;
    assign m_ov    = sel ? ov8 : ov4;
    assign m_deg   = sel ? deg8 : deg4;
    assign m_bf    = sel ? bf8 : bf4;
    assign m_cul   = sel ? cul8 : cul4;
    assign m_area  = sel ? area8 : area4;
    assign m_recip = sel ? recip8 : recip4;
    assign m_tag   = sel ? tag8 : tag4;

    triangle_area_recip_unit #(.W(W), .FRAC(4), .TAG_W(TAG_W)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv4), .in_ready(ir4),
        .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
        .cull_mode(cm), .in_tag(tg), .out_valid(ov4), .out_ready(ordy4),
        .area_out(area4), .recip_out(recip4), .degenerate(deg4), .backface(bf4),
        .culled(cul4), .out_tag(tag4)
    );

    triangle_area_recip_unit #(.W(W), .FRAC(8), .TAG_W(TAG_W)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .in_valid(iv8), .in_ready(ir8),
        .v0x(v0x), .v0y(v0y), .v1x(v1x), .v1y(v1y), .v2x(v2x), .v2y(v2y),
        .cull_mode(cm), .in_tag(tg), .out_valid(ov8), .out_ready(ordy8),
        .area_out(area8), .recip_out(recip8), .degenerate(deg8), .backface(bf8),
        .culled(cul8), .out_tag(tag8)
    );

    int n_cmp = 0;
    int n_err = 0;

    task automatic check_eq(input string name, input longint got, input longint exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    function automatic longint sat(input longint x);
        longint lim;
        lim = (longint'(1) << (W - 1)) - 1;
        if (x > lim) return lim;
        if (x < -lim) return -lim;
        return x;
    endfunction

    // Reference: exact doubled area, floor shift, truncating divide, symmetric clamp
    task automatic model(input longint x0, input longint y0, input longint x1,
                         input longint y1, input longint x2, input longint y2,
                         input int c, input int frac,
                         output longint a, output longint r, output longint dg,
                         output longint bk, output longint cu, output int lat);
        longint e, ar;
        e  = (x1 - x0) * (y2 - y0) - (y1 - y0) * (x2 - x0);
        ar = e >>> frac;
        bk = (e < 0) ? 1 : 0;
        dg = (ar == 0) ? 1 : 0;
        cu = ((c == 1 && e < 0) || (c == 2 && e > 0)) ? 1 : 0;
        a  = sat(ar);
        if (dg != 0 || cu != 0) begin
            r   = 0;
            lat = 4;
        end else begin
            r   = sat((longint'(1) << (2 * frac)) / ar);
            lat = 4 + 2 * frac + 1;
        end
    endtask

    task automatic check_outs(input longint a, input longint r, input longint dg,
                              input longint bk, input longint cu, input int t);
        check_eq("area_out", m_area, a);
        check_eq("recip_out", m_recip, r);
        check_eq("degenerate", m_deg, dg);
        check_eq("backface", m_bf, bk);
        check_eq("culled", m_cul, cu);
        check_eq("out_tag", m_tag, t);
    endtask

    // Send one triangle, measure latency, check result, optionally stall and pulse in_valid
    task automatic run_tri(input int x0, input int y0, input int x1, input int y1,
                           input int x2, input int y2, input int c, input int t,
                           input int hold, input bit pulse, input int frac);
        longint ea, er, ed, eb, ec;
        int     el, lat;
        model(x0, y0, x1, y1, x2, y2, c, frac, ea, er, ed, eb, ec, el);
        @(negedge clk);
        v0x = W'(x0); v0y = W'(y0); v1x = W'(x1); v1y = W'(y1); v2x = W'(x2); v2y = W'(y2);
        cm  = 2'(c);
        tg  = TAG_W'(t);
        iv  = 1'b1;
        check_eq("in_ready_idle", m_ir, 1);
        @(posedge clk);
        #1 iv = 1'b0;
        lat = 1;
        while (!m_ov && lat < 200) begin
            @(posedge clk);
            #1 lat++;
        end
        check_eq("latency", lat, el);
        check_outs(ea, er, ed, eb, ec, t);
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (pulse && h == 2) begin
                iv  = 1'b1;
                v0x = ~v0x;
                tg  = ~tg;
            end else begin
                iv = 1'b0;
            end
            @(posedge clk);
            #1;
            check_eq("hold_valid", m_ov, 1);
            check_eq("hold_in_ready", m_ir, 0);
            check_outs(ea, er, ed, eb, ec, t);
        end
        @(negedge clk);
        iv   = 1'b0;
        ordy = 1'b1;
        @(posedge clk);
        #1 ordy = 1'b0;
        check_eq("post_hs_in_ready", m_ir, 1);
        check_eq("post_hs_valid", m_ov, 0);
        if (pulse) begin
            @(posedge clk);
            #1 check_eq("pulse_not_latched", m_ir, 1);
        end
    endtask

    function automatic int rnd_c(input int mode);
        if (mode == 0) return int'($urandom_range(0, 128)) - 64;
        return int'($urandom_range(0, 65535)) - 32768;
    endfunction

    initial begin
        int seen;
        int x0, y0, x1, y1, x2, y2, md;
        rst_n = 1'b0;
        sel   = 1'b0;
        iv    = 1'b0;
        ordy  = 1'b0;
        v0x = '0; v0y = '0; v1x = '0; v1y = '0; v2x = '0; v2y = '0;
        cm  = '0;
        tg  = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_out_valid", m_ov, 0);
        check_eq("rst_in_ready", m_ir, 1);
        check_outs(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Directed FRAC=4 cases
        run_tri(0, 0, 64, 0, 0, 32, 0, 'h5A, 0, 1'b0, 4);
        run_tri(0, 0, 0, 32, 64, 0, 0, 'h33, 0, 1'b0, 4);
        run_tri(0, 0, 0, 32, 64, 0, 1, 'h34, 0, 1'b0, 4);
        run_tri(0, 0, 64, 0, 0, 32, 2, 'h35, 0, 1'b0, 4);
        for (int c = 0; c < 4; c++) run_tri(0, 0, 16, 16, 32, 32, c, 'h40 + c, 0, 1'b0, 4);
        run_tri(0, 0, 1, 0, 0, 15, 0, 'h50, 0, 1'b0, 4);
        run_tri(0, 0, 0, 15, 1, 0, 0, 'h51, 0, 1'b0, 4);
        run_tri(-32768, -32768, 32767, -32768, -32768, 32767, 0, 'h52, 0, 1'b0, 4);
        run_tri(0, 0, 1, 0, 0, 16, 0, 'h53, 0, 1'b0, 4);

        // Backpressure with a stray in_valid pulse, then a fresh triangle
        run_tri(0, 0, 64, 0, 0, 32, 0, 'h77, 20, 1'b1, 4);
        run_tri(10, -5, 300, 40, -20, 500, 0, 'h11, 0, 1'b0, 4);

        // Reset while the divider is running
        @(negedge clk);
        v0x = 0; v0y = 0; v1x = 64; v1y = 0; v2x = 0; v2y = 32; cm = 0; tg = 8'hEE;
        iv = 1'b1;
        @(posedge clk);
        #1 iv = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        check_eq("midrst_out_valid", m_ov, 0);
        check_eq("midrst_in_ready", m_ir, 1);
        check_outs(0, 0, 0, 0, 0, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        repeat (20) begin
            @(posedge clk);
            #1 if (m_ov) seen = 1;
        end
        check_eq("midrst_no_emit", seen, 0);
        run_tri(3, 7, -100, 20, 50, 90, 0, 'h21, 0, 1'b0, 4);

        // FRAC=8 instance: reciprocal saturation both signs
        sel = 1'b1;
        run_tri(0, 0, 1, 0, 0, 256, 0, 'hA1, 0, 1'b0, 8);
        run_tri(0, 0, 0, 256, 1, 0, 0, 'hA2, 0, 1'b0, 8);
        for (int i = 0; i < 10; i++) begin
            md = int'($urandom_range(0, 1));
            x0 = rnd_c(md); y0 = rnd_c(md); x1 = rnd_c(md);
            y1 = rnd_c(md); x2 = rnd_c(md); y2 = rnd_c(md);
            run_tri(x0, y0, x1, y1, x2, y2, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, 8);
        end

        // Random FRAC=4 triangles, including forced collinear ones
        sel = 1'b0;
        for (int i = 0; i < 40; i++) begin
            md = int'($urandom_range(0, 2));
            x0 = rnd_c(md == 1 ? 1 : 0); y0 = rnd_c(md == 1 ? 1 : 0);
            x1 = rnd_c(md == 1 ? 1 : 0); y1 = rnd_c(md == 1 ? 1 : 0);
            x2 = rnd_c(md == 1 ? 1 : 0); y2 = rnd_c(md == 1 ? 1 : 0);
            if (md == 2 && $urandom_range(0, 1) == 1) begin
                x2 = 2 * x1 - x0;
                y2 = 2 * y1 - y0;
            end
            run_tri(x0, y0, x1, y1, x2, y2, int'($urandom_range(0, 3)),
                    int'($urandom_range(0, 255)), int'($urandom_range(0, 3)), 1'b0, 4);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
